// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg
// Shared types and helpers for the CPU bus master and its lane-steering logic.
//   size_t     : access width requested by the core (byte/half/word, 11 is illegal)
//   state_t    : bus master controller states
//   misaligned : true when an access of the given size cannot start at this byte offset
package mips_cpu_bus_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUS    = 3'd1,
      RDWAIT = 3'd2,
      ERR    = 3'd3,
      RESP   = 3'd4
   } state_t;

   // Halfwords must sit on an even address and words on a multiple of four.
   // Byte accesses are always aligned. The illegal size is reported separately.
   function automatic logic misaligned(input size_t size, input logic [1:0] addr_lo);
      logic result;
      case (size)
         SZ_HALF: result = addr_lo[0];
         SZ_WORD: result = (addr_lo != 2'b00);
         default: result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/mips_cpu_bus_lane_align.sv
// mips_cpu_bus_lane_align
// Purely combinational little-endian lane steering for the bus master.
// Ports:
//   size        in   access width of the captured request
//   offset      in   byte offset within the word (address bits [1:0])
//   sign_ext    in   1 = sign-extend loads, 0 = zero-extend
//   store_data  in   right-justified store data from the core
//   bus_rdata   in   raw 32-bit word returned by the bus
//   lane_enable out  byte lanes touched by the access
//   lane_wdata  out  store data replicated across every lane of its width
//   load_data   out  selected load bytes, extended to 32 bits
module mips_cpu_bus_lane_align
   import mips_cpu_bus_pkg::*;
(
   input  size_t       size,
   input  logic [1:0]  offset,
   input  logic        sign_ext,
   input  logic [31:0] store_data,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  lane_enable,
   output logic [31:0] lane_wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick out the addressed byte and halfword from the returned word.
   always_comb begin
      byte_sel = 8'h00;
      case (offset)
         2'd0: byte_sel = bus_rdata[7:0];
         2'd1: byte_sel = bus_rdata[15:8];
         2'd2: byte_sel = bus_rdata[23:16];
         2'd3: byte_sel = bus_rdata[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
   end

   // Store data is replicated rather than shifted so that every enabled lane
   // already carries the right bits; the slave only honours the enabled ones.
   always_comb begin
      lane_enable = 4'b0000;
      lane_wdata  = 32'h0000_0000;
      load_data   = 32'h0000_0000;
      case (size)
         SZ_BYTE: begin
            lane_enable = 4'b0001 << offset;
            lane_wdata  = {4{store_data[7:0]}};
            load_data   = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            lane_enable = offset[1] ? 4'b1100 : 4'b0011;
            lane_wdata  = {2{store_data[15:0]}};
            load_data   = {{16{sign_ext & half_sel[15]}}, half_sel};
         end
         SZ_WORD: begin
            lane_enable = 4'b1111;
            lane_wdata  = store_data;
            load_data   = bus_rdata;
         end
         default: begin
            lane_enable = 4'b0000;
            lane_wdata  = 32'h0000_0000;
            load_data   = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// mips_cpu_bus_master
// CPU-side initiator for the word-addressed Avalon-style memory bus. Takes one
// load/store at a time from the core, runs a word-aligned bus cycle with byte
// enables, honours waitrequest and returns extended load data.
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   req_valid/req_ready              core request handshake (ready only in IDLE)
//   req_write/req_size/req_signed    access kind, width and load extension
//   req_addr/req_wdata               byte address and right-justified store data
//   rsp_valid/rsp_rdata/rsp_err      one-cycle completion pulse with result
//   address/read/write/byteenable/writedata/waitrequest/readdata   memory bus
module mips_cpu_bus_master
   import mips_cpu_bus_pkg::*;
#(
   parameter int RD_LATENCY = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   localparam logic [1:0] LAT_LAST = 2'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

   state_t      state;
   size_t       size_q;
   logic        write_q;
   logic        signed_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  lat_cnt;

   logic [3:0]  lane_enable;
   logic [31:0] lane_wdata;
   logic [31:0] load_data;

   mips_cpu_bus_lane_align u_lane_align (
      .size        (size_q),
      .offset      (addr_q[1:0]),
      .sign_ext    (signed_q),
      .store_data  (wdata_q),
      .bus_rdata   (readdata),
      .lane_enable (lane_enable),
      .lane_wdata  (lane_wdata),
      .load_data   (load_data)
   );

   // Bus outputs are decoded from registered state and the captured request,
   // so they stay stable for as long as the slave holds waitrequest.
   assign req_ready  = (state == IDLE);
   assign rsp_valid  = (state == RESP);
   assign read       = (state == BUS) & ~write_q;
   assign write      = (state == BUS) & write_q;
   assign address    = {addr_q[31:2], 2'b00};
   assign byteenable = (state == BUS) ? lane_enable : 4'b0000;
   assign writedata  = lane_wdata;

   // Controller: capture the request in IDLE, run the bus cycle, wait out the
   // read latency, then pulse the response for exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         size_q    <= SZ_BYTE;
         write_q   <= 1'b0;
         signed_q  <= 1'b0;
         addr_q    <= 32'h0000_0000;
         wdata_q   <= 32'h0000_0000;
         lat_cnt   <= 2'd0;
         rsp_rdata <= 32'h0000_0000;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  size_q    <= size_t'(req_size);
                  write_q   <= req_write;
                  signed_q  <= req_signed;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  rsp_rdata <= 32'h0000_0000;
                  rsp_err   <= 1'b0;
                  if ((size_t'(req_size) == SZ_BAD) || misaligned(size_t'(req_size), req_addr[1:0]))
                     state <= ERR;
                  else
                     state <= BUS;
               end
            end
            BUS: begin
               if (!waitrequest) begin
                  if (write_q) begin
                     state <= RESP;
                  end else if (RD_LATENCY == 0) begin
                     rsp_rdata <= load_data;
                     state     <= RESP;
                  end else begin
                     lat_cnt <= LAT_LAST;
                     state   <= RDWAIT;
                  end
               end
            end
            RDWAIT: begin
               if (lat_cnt == 2'd0) begin
                  rsp_rdata <= load_data;
                  state     <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            ERR: begin
               rsp_err <= 1'b1;
               state   <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// tb_mips_cpu_bus_master
// Self-checking bench: a table of directed transactions with hand-derived
// expectations, a mid-transfer reset sequence, and randomized transactions
// checked against an arithmetic model of the bus master's rules.
module tb_mips_cpu_bus_master;

   localparam int RD_LAT = 1;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;

   int checks;
   int failures;

   typedef struct {
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vectors [12];

   mips_cpu_bus_master #(.RD_LATENCY(RD_LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_size    (req_size),
      .req_signed  (req_signed),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .address     (address),
      .read        (read),
      .write       (write),
      .byteenable  (byteenable),
      .writedata   (writedata),
      .waitrequest (waitrequest),
      .readdata    (readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   function automatic vec_t mk(input logic write, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                               input int waits, input logic [3:0] be, input logic [31:0] ewd,
                               input logic [31:0] erd, input logic err);
      vec_t v;
      v.write = write; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.waits = waits; v.exp_be = be; v.exp_wdata = ewd;
      v.exp_rdata = erd; v.exp_err = err;
      return v;
   endfunction

   // Reference model: expectations from the access rules with plain arithmetic
   // (shifts to pick lanes, multiplication to replicate, subtraction to sign-extend).
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int unsigned k;
      logic [31:0] lane;
      r = v;
      k = 32'(v.addr[1:0]);
      r.exp_err = (v.size == 2'd3) || (v.size == 2'd1 && v.addr[0]) || (v.size == 2'd2 && k != 0);
      r.exp_be = 4'h0; r.exp_wdata = 32'h0; r.exp_rdata = 32'h0;
      lane = 32'h0;
      if (!r.exp_err) begin
         if (v.size == 2'd0) begin
            r.exp_be    = 4'(1 << k);
            r.exp_wdata = (v.wdata & 32'hFF) * 32'h0101_0101;
            lane        = (v.rdata >> (8 * k)) & 32'hFF;
            if (v.sgn && lane >= 32'd128) lane = lane - 32'd256;
         end else if (v.size == 2'd1) begin
            r.exp_be    = 4'(3 << k);
            r.exp_wdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
            lane        = (v.rdata >> (8 * k)) & 32'hFFFF;
            if (v.sgn && lane >= 32'd32768) lane = lane - 32'd65536;
         end else begin
            r.exp_be    = 4'hF;
            r.exp_wdata = v.wdata;
            lane        = v.rdata;
         end
         if (!v.write) r.exp_rdata = lane;
      end
      return r;
   endfunction

   // Drives one request, plays the slave (waitrequest stalls, readdata valid
   // only in the cycle RD_LAT after the accepted read), and checks the result.
   task automatic applyStimulus(input string tag, input vec_t v);
      int cycles, wait_left, strobe_cycles, wrong_strobe, ready_busy, unstable, exp_lat;
      logic data_next, got;
      logic [31:0] first_addr, first_wd, got_rdata;
      logic [3:0]  first_be;
      logic        got_err;
      cycles = 0; wait_left = v.waits; strobe_cycles = 0; wrong_strobe = 0;
      ready_busy = 0; unstable = 0; data_next = 1'b0; got = 1'b0;
      first_addr = 32'h0; first_wd = 32'h0; first_be = 4'h0; got_rdata = 32'h0; got_err = 1'b0;

      checkOutput({tag, " ready_idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = v.write; req_size = v.size; req_signed = v.sgn;
      req_addr = v.addr; req_wdata = v.wdata; waitrequest = 1'b0; readdata = ~v.rdata;
      @(posedge clk); #1;

      while (!got && cycles < 50) begin
         cycles++;
         // Busy-time request inputs are garbage and must be ignored.
         req_valid = 1'b1; req_write = 1'($urandom); req_size = 2'($urandom);
         req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
         readdata = data_next ? v.rdata : $urandom;
         data_next = 1'b0;
         if (rsp_valid) begin
            got = 1'b1;
            got_rdata = rsp_rdata;
            got_err = rsp_err;
            req_valid = 1'b0;
            waitrequest = 1'b0;
         end else begin
            if (req_ready) ready_busy++;
            if (read || write) begin
               strobe_cycles++;
               if (write !== v.write || read !== !v.write) wrong_strobe++;
               if (strobe_cycles == 1) begin
                  first_addr = address; first_be = byteenable; first_wd = writedata;
               end else if (address !== first_addr || byteenable !== first_be ||
                            (v.write && writedata !== first_wd)) begin
                  unstable++;
               end
               if (wait_left > 0) begin
                  waitrequest = 1'b1;
                  wait_left--;
               end else begin
                  waitrequest = 1'b0;
                  if (read) data_next = (RD_LAT > 0);
               end
            end else begin
               waitrequest = 1'b0;
            end
         end
         @(posedge clk); #1;
      end

      if (!got) begin
         checkOutput({tag, " rsp_timeout"}, 32'(got), 32'd1);
      end else begin
         exp_lat = v.exp_err ? 2 : (2 + v.waits + (v.write ? 0 : RD_LAT));
         checkOutput({tag, " latency"}, 32'(cycles), 32'(exp_lat));
         checkOutput({tag, " strobe_cycles"}, 32'(strobe_cycles), v.exp_err ? 32'd0 : 32'(v.waits + 1));
         checkOutput({tag, " wrong_strobe"}, 32'(wrong_strobe), 32'd0);
         checkOutput({tag, " ready_busy"}, 32'(ready_busy), 32'd0);
         checkOutput({tag, " bus_stable"}, 32'(unstable), 32'd0);
         if (!v.exp_err) begin
            checkOutput({tag, " address"}, first_addr, v.addr & 32'hFFFF_FFFC);
            checkOutput({tag, " byteenable"}, 32'(first_be), 32'(v.exp_be));
            if (v.write) checkOutput({tag, " writedata"}, first_wd, v.exp_wdata);
         end
         checkOutput({tag, " rsp_rdata"}, got_rdata, v.exp_rdata);
         checkOutput({tag, " rsp_err"}, 32'(got_err), 32'(v.exp_err));
         checkOutput({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; waitrequest = 1'b0; readdata = 32'h0;

      // Directed vectors: write, size, signed, addr, wdata, rdata, waits, be, wdata, rdata, err
      vectors[0]  = mk(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
      vectors[1]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
      vectors[2]  = mk(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0);
      vectors[3]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 4'b1100, 32'h0, 32'h0000_8001, 1'b0);
      vectors[4]  = mk(1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'h0, 32'h0000_7F00, 3, 4'b0010, 32'h0, 32'h0000_007F, 1'b0);
      vectors[5]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 32'h1111_1111, 0, 4'b0000, 32'h0, 32'h0, 1'b1);
      vectors[6]  = mk(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 32'h2222_2222, 0, 4'b0000, 32'h0, 32'h0, 1'b1);
      vectors[7]  = mk(1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_00F0, 0, 4'b0001, 32'h0, 32'hFFFF_FFF0, 1'b0);
      vectors[8]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_0302, 32'h1234_ABCD, 32'h0, 1, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
      vectors[9]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h9A00_0000, 0, 4'b1000, 32'h0, 32'h0000_009A, 1'b0);
      vectors[10] = mk(1'b0, 2'd2, 1'b1, 32'h0000_0040, 32'h0, 32'h1234_5678, 2, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);
      vectors[11] = mk(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h5555_6666, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1);

      #12;
      checkOutput("reset req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset strobes", 32'({read, write}), 32'd0);
      checkOutput("reset byteenable", 32'(byteenable), 32'd0);
      checkOutput("reset address", address, 32'h0);
      checkOutput("reset writedata", writedata, 32'h0);
      checkOutput("reset rsp", 32'({rsp_valid, rsp_err}), 32'd0);
      checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         applyStimulus($sformatf("vec%0d", i), vectors[i]);
      end

      // Reset while a read is stalled: strobe must drop without waiting for a clock.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h0000_0080; waitrequest = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("stall read_c1", 32'(read), 32'd1);
      @(posedge clk); #1;
      checkOutput("stall read_c2", 32'(read), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset read", 32'(read), 32'd0);
      checkOutput("async_reset address", address, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; waitrequest = 1'b0;
      @(posedge clk); #1;
      checkOutput("post_reset req_ready", 32'(req_ready), 32'd1);
      applyStimulus("after_reset", vectors[2]);

      // Randomized transactions against the model.
      for (int n = 0; n < 40; n++) begin
         vec_t v;
         v.write = 1'($urandom); v.size = 2'($urandom); v.sgn = 1'($urandom);
         v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
         v.waits = $urandom_range(0, 3);
         v.exp_be = 4'h0; v.exp_wdata = 32'h0; v.exp_rdata = 32'h0; v.exp_err = 1'b0;
         applyStimulus($sformatf("rand%0d", n), model(v));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
